stack_fetch_sequencer: RTL

Fetch-side sequencer of the stack-based multi-cycle processor, on the opposite end of the program-counter interface. It reads the current PC and fetches the instruction word from instruction memory over a req/ready handshake. It holds the word in an instruction register for the execute controller, then drives `next_pc`/`pc_enable` back into the PC register for either a sequential advance or a branch. A halt request parks the unit until reset.

---
 rtl/stack_cpu_pkg.sv | 15 +
 rtl/stack_fetch_sequencer.sv | 95 +++++++++
 2 files changed

// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the stack-based multi-cycle processor.
package stack_cpu_pkg;

    localparam int STACK_ADDR_WIDTH  = 4;
    localparam int STACK_INSTR_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_EXEC    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_HALTED  = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/stack_fetch_sequencer.sv
// Fetch-side sequencer: reads the instruction at the current PC, holds it in
// the instruction register while the execute controller works on it, then
// strobes the external PC register with the sequential or branch address.
module stack_fetch_sequencer
    import stack_cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = STACK_ADDR_WIDTH,
    parameter int INSTR_WIDTH = STACK_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    output logic                   pc_enable,
    output logic [ADDR_WIDTH-1:0]  next_pc,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic [INSTR_WIDTH-1:0] ir,
    output logic                   ir_valid,
    input  logic                   exec_done,
    input  logic                   branch_taken,
    input  logic [ADDR_WIDTH-1:0]  branch_target,
    input  logic                   halt,
    output logic                   halted
);

    fetch_state_t state, state_next;

    // The memory always reads at the address the PC register presents.
    assign mem_addr = pc_in;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and Moore output decodes.
    always_comb begin
        state_next = state;
        mem_req    = 1'b0;
        ir_valid   = 1'b0;
        pc_enable  = 1'b0;
        halted     = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                ir_valid = 1'b1;
                if (exec_done) begin
                    state_next = halt ? ST_HALTED : ST_ADVANCE;
                end
            end
            ST_ADVANCE: begin
                pc_enable  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALTED: begin
                halted = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Instruction register and next-PC register; each loads only at its
    // accepting edge and otherwise holds until reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir      <= '0;
            next_pc <= '0;
        end else begin
            if (state == ST_FETCH && mem_ready) begin
                ir <= mem_rdata;
            end
            if (state == ST_EXEC && exec_done && !halt) begin
                // Sequential advance wraps naturally at the register width.
                next_pc <= branch_taken ? branch_target : pc_in + ADDR_WIDTH'(1);
            end
        end
    end

endmodule
